// File: rtl/core_axi_bridge.sv
// Bridges one core SRAM-style port to a single-beat AXI4 master.
// One load/store is in flight at a time, and the core is stalled through sync until it completes.
module core_axi_bridge #(
    parameter int          CPU_ADDR_BITS = 14,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req_r,
    input  logic [CPU_ADDR_BITS-1:0] cpu_addr,
    input  logic [3:0]               cpu_write_en,
    input  logic [31:0]              cpu_wdata,
    output logic [31:0]              cpu_rdata,
    output logic                     sync,
    output logic                     bus_err,
    output logic [31:0]              araddr,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [31:0]              awaddr,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    // state | meaning
    // IDLE  | waiting for a core request
    // RADDR | AR channel valid, waiting for arready
    // RDATA | rready high, waiting for rvalid
    // WADDR | AW and W valid, each dropped after its own handshake
    // WRESP | bready high, waiting for bvalid
    // DONE  | single unstalled cycle so the core pipeline advances
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WRESP = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_bus_err;
    logic        w_is_wr;
    logic        w_new_req;
    logic        w_accept;

    assign w_is_wr   = |cpu_write_en;
    assign w_new_req = cpu_req_r | w_is_wr;
    assign w_accept  = (r_state == IDLE) && w_new_req;

    assign araddr    = r_addr;
    assign awaddr    = r_addr;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign cpu_rdata = r_rdata;
    assign bus_err   = r_bus_err;

    always_comb begin
        w_next  = r_state;
        sync    = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_new_req) begin
                    sync   = 1'b1;
                    w_next = w_is_wr ? WADDR : RADDR;
                end
            end
            RADDR: begin
                sync    = 1'b1;
                arvalid = 1'b1;
                if (arready) w_next = RDATA;
            end
            RDATA: begin
                sync   = 1'b1;
                rready = 1'b1;
                if (rvalid) w_next = DONE;
            end
            WADDR: begin
                sync    = 1'b1;
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                if ((r_aw_done | awready) && (r_w_done | wready)) w_next = WRESP;
            end
            WRESP: begin
                sync   = 1'b1;
                bready = 1'b1;
                if (bvalid) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_rdata   <= 32'h0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_bus_err <= ((r_state == RDATA) && rvalid && (rresp != 2'b00)) ||
                         ((r_state == WRESP) && bvalid && (bresp != 2'b00));
            // Payload is latched once so later core input changes cannot disturb AXI.
            if (w_accept) begin
                r_addr    <= {BASE_ADDR[31:CPU_ADDR_BITS+2], cpu_addr, 2'b00};
                r_wdata   <= cpu_wdata;
                r_wstrb   <= cpu_write_en;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (r_state == WADDR) begin
                if (awvalid && awready) r_aw_done <= 1'b1;
                if (wvalid && wready)   r_w_done  <= 1'b1;
            end
            if ((r_state == RDATA) && rvalid) r_rdata <= rdata;
        end
    end

endmodule

// File: tb/tb_core_axi_bridge.sv
// Directed bench for core_axi_bridge: reset, reads, writes, priority, back-to-back and error response.
module tb_core_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_r;
    logic [13:0] cpu_addr;
    logic [3:0]  cpu_write_en;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        sync;
    logic        bus_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_pass  = 0;
    int n_total = 0;
    int n_ar    = 0;

    core_axi_bridge #(
        .CPU_ADDR_BITS(14),
        .BASE_ADDR    (32'h0001_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_r   (cpu_req_r),
        .cpu_addr    (cpu_addr),
        .cpu_write_en(cpu_write_en),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .sync        (sync),
        .bus_err     (bus_err),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready),
        .awaddr      (awaddr),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wvalid      (wvalid),
        .wready      (wready),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && arvalid && arready) n_ar++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; cpu_req_r = 1'b0; cpu_addr = '0; cpu_write_en = '0; cpu_wdata = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
        #12;
        chk("rst_sync", {31'b0, sync}, 32'h0);
        chk("rst_arvalid", {31'b0, arvalid}, 32'h0);
        chk("rst_awvalid", {31'b0, awvalid}, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
        rst = 1'b1;
        tick();

        // reset in the middle of a read with arvalid high
        cpu_req_r = 1'b1; cpu_addr = 14'h0004;
        tick();
        cpu_req_r = 1'b0;
        #1;
        chk("mid_arvalid_pre", {31'b0, arvalid}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid_arvalid_rst", {31'b0, arvalid}, 32'h0);
        chk("mid_sync_rst", {31'b0, sync}, 32'h0);
        chk("mid_araddr_rst", araddr, 32'h0);
        #3 rst = 1'b1;
        tick();
        chk("mid_sync_after", {31'b0, sync}, 32'h0);
        chk("mid_arvalid_after", {31'b0, arvalid}, 32'h0);
        chk("mid_rready_after", {31'b0, rready}, 32'h0);

        // read, addr 4, rvalid on second RDATA cycle
        cpu_req_r = 1'b1; cpu_addr = 14'h0004; arready = 1'b1;
        #1;
        chk("rd_sync_c1", {31'b0, sync}, 32'h1);
        tick();
        cpu_req_r = 1'b0; cpu_addr = 14'h3FFF;
        #1;
        chk("rd_arvalid", {31'b0, arvalid}, 32'h1);
        chk("rd_araddr", araddr, 32'h0001_0010);
        chk("rd_sync_c2", {31'b0, sync}, 32'h1);
        tick();
        chk("rd_arvalid_off", {31'b0, arvalid}, 32'h0);
        chk("rd_rready", {31'b0, rready}, 32'h1);
        chk("rd_sync_c3", {31'b0, sync}, 32'h1);
        tick();
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        #1;
        chk("rd_sync_c4", {31'b0, sync}, 32'h1);
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        chk("rd_done_sync", {31'b0, sync}, 32'h0);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_done_bus_err", {31'b0, bus_err}, 32'h0);
        chk("rd_araddr_hold", araddr, 32'h0001_0010);
        tick();
        chk("rd_idle_sync", {31'b0, sync}, 32'h0);

        // write, wready three cycles after awready
        cpu_write_en = 4'b0011; cpu_wdata = 32'h1234_5678; cpu_addr = 14'h0100;
        awready = 1'b1; wready = 1'b0;
        #1;
        chk("wr_sync_c1", {31'b0, sync}, 32'h1);
        tick();
        cpu_write_en = 4'b0000; cpu_wdata = 32'hFFFF_FFFF;
        #1;
        chk("wr_awvalid_c1", {31'b0, awvalid}, 32'h1);
        chk("wr_wvalid_c1", {31'b0, wvalid}, 32'h1);
        chk("wr_wstrb", {28'b0, wstrb}, 32'h3);
        chk("wr_wdata", wdata, 32'h1234_5678);
        chk("wr_awaddr", awaddr, 32'h0001_0400);
        tick();
        awready = 1'b0;
        chk("wr_awvalid_c2", {31'b0, awvalid}, 32'h0);
        chk("wr_wvalid_c2", {31'b0, wvalid}, 32'h1);
        tick();
        chk("wr_wvalid_c3", {31'b0, wvalid}, 32'h1);
        tick();
        wready = 1'b1;
        chk("wr_wvalid_c4", {31'b0, wvalid}, 32'h1);
        chk("wr_wdata_stable", wdata, 32'h1234_5678);
        tick();
        wready = 1'b0;
        chk("wr_wvalid_off", {31'b0, wvalid}, 32'h0);
        chk("wr_bready", {31'b0, bready}, 32'h1);
        chk("wr_sync_wresp", {31'b0, sync}, 32'h1);
        tick();
        bvalid = 1'b1; bresp = 2'b00;
        #1;
        chk("wr_sync_bvalid", {31'b0, sync}, 32'h1);
        tick();
        bvalid = 1'b0;
        chk("wr_done_sync", {31'b0, sync}, 32'h0);
        chk("wr_done_bus_err", {31'b0, bus_err}, 32'h0);
        chk("wr_cpu_rdata_kept", cpu_rdata, 32'hDEADBEEF);
        tick();

        // read and write together: write wins
        n_ar = 0;
        cpu_req_r = 1'b1; cpu_write_en = 4'hF; cpu_wdata = 32'hAABB_CCDD; cpu_addr = 14'h0008;
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("both_sync", {31'b0, sync}, 32'h1);
        tick();
        cpu_req_r = 1'b0; cpu_write_en = 4'h0;
        chk("both_arvalid", {31'b0, arvalid}, 32'h0);
        chk("both_awvalid", {31'b0, awvalid}, 32'h1);
        chk("both_wvalid", {31'b0, wvalid}, 32'h1);
        chk("both_wstrb", {28'b0, wstrb}, 32'hF);
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        chk("both_bready", {31'b0, bready}, 32'h1);
        chk("both_arvalid_wresp", {31'b0, arvalid}, 32'h0);
        tick();
        bvalid = 1'b0;
        chk("both_done_sync", {31'b0, sync}, 32'h0);
        chk("both_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();
        chk("both_no_ar", n_ar, 32'd0);

        // back-to-back reads of the same address
        n_ar = 0;
        cpu_req_r = 1'b1; cpu_addr = 14'h0004; arready = 1'b1;
        #1;
        chk("b2b_sync_1", {31'b0, sync}, 32'h1);
        tick();
        chk("b2b_arvalid_1", {31'b0, arvalid}, 32'h1);
        tick();
        rvalid = 1'b1; rdata = 32'h1111_2222;
        tick();
        rvalid = 1'b0;
        chk("b2b_done_sync", {31'b0, sync}, 32'h0);
        chk("b2b_rdata_1", cpu_rdata, 32'h1111_2222);
        tick();
        chk("b2b_sync_2", {31'b0, sync}, 32'h1);
        chk("b2b_idle_arvalid", {31'b0, arvalid}, 32'h0);
        tick();
        cpu_req_r = 1'b0;
        chk("b2b_arvalid_2", {31'b0, arvalid}, 32'h1);
        tick();
        rvalid = 1'b1; rdata = 32'h3333_4444;
        tick();
        rvalid = 1'b0;
        chk("b2b_rdata_2", cpu_rdata, 32'h3333_4444);
        chk("b2b_ar_count", n_ar, 32'd2);
        tick();

        // error read response
        cpu_req_r = 1'b1; cpu_addr = 14'h0002; arready = 1'b1;
        tick();
        cpu_req_r = 1'b0;
        tick();
        rvalid = 1'b1; rresp = 2'b10; rdata = 32'hCAFE_F00D;
        #1;
        chk("err_bus_err_pre", {31'b0, bus_err}, 32'h0);
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        chk("err_bus_err_pulse", {31'b0, bus_err}, 32'h1);
        chk("err_cpu_rdata", cpu_rdata, 32'hCAFE_F00D);
        tick();
        chk("err_bus_err_clear", {31'b0, bus_err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
